instr_fetch_unit: RTL

- Front end of the single-cycle core.
- Keeps the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction, with its decoded fields (op, funct3, funct7b5, opb5), to the control unit and datapath over a valid/ready handshake.
- Accepts PC redirects (pcsrc + target) from the execute side, including while a memory request is in flight.

---
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Front end of the single-cycle core: owns the PC, fetches words over imem req/ack
// and hands each instruction plus its decoded control fields to the core over valid/ready.
module instr_fetch_unit #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_out,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic            opb5,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] pc_target,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] redir_nxt;
  logic [XLEN-1:0] instr_nxt;
  logic [XLEN-1:0] pc_out_nxt;
  logic [31:0]     count_nxt;
  logic [XLEN-1:0] target;
  logic            ack;

  assign target = {pc_target[XLEN-1:2], 2'b00};
  // An ack is only meaningful while a request is actually on the bus.
  assign ack    = imem_ack & imem_req;

  // Next-state and datapath selection for the fetch state machine.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    redir_nxt  = redir_pc;
    instr_nxt  = instr;
    pc_out_nxt = pc_out;
    count_nxt  = fetch_count;
    case (state)
      FETCH: begin
        if (ack) begin
          if (pcsrc) begin
            pc_nxt = target;
          end else begin
            instr_nxt  = imem_rdata;
            pc_out_nxt = pc;
            state_nxt  = HOLD;
          end
        end else if (pcsrc) begin
          redir_nxt = target;
          state_nxt = DROP;
        end else begin
          state_nxt = FETCH;
        end
      end
      DROP: begin
        if (pcsrc) begin
          redir_nxt = target;
        end else begin
          redir_nxt = redir_pc;
        end
        // The stale word is thrown away; the latest redirect decides the next PC.
        if (ack) begin
          pc_nxt    = pcsrc ? target : redir_pc;
          state_nxt = FETCH;
        end else begin
          state_nxt = DROP;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          count_nxt = fetch_count + 32'd1;
          pc_nxt    = pcsrc ? target : (pc_out + 32'd4);
          state_nxt = FETCH;
        end else if (pcsrc) begin
          pc_nxt    = target;
          state_nxt = FETCH;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // State, PC and output registers; reset drops the request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redir_pc    <= 32'h0000_0000;
      instr       <= 32'h0000_0013;
      pc_out      <= RESET_PC;
      fetch_count <= 32'h0000_0000;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      redir_pc    <= redir_nxt;
      instr       <= instr_nxt;
      pc_out      <= pc_out_nxt;
      fetch_count <= count_nxt;
      imem_req    <= (state_nxt != HOLD);
      instr_valid <= (state_nxt == HOLD);
    end
  end

  assign imem_addr = pc;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7b5  = instr[30];
  assign opb5      = instr[5];

endmodule
